// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier datapath and its
// product accumulator.
package booth_pkg;

  localparam int PW_DEF = 64;
  localparam int AW_DEF = 72;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } acc_state_t;

  localparam logic [AW_DEF-1:0] ACC_MAX = {1'b0, {(AW_DEF-1){1'b1}}};
  localparam logic [AW_DEF-1:0] ACC_MIN = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream, result output stream and group configuration.
interface product_accumulator_if
  import booth_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
);

  logic [LW-1:0] cfg_len;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;
  logic          busy;

  modport master (
    output cfg_len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  cfg_len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/sat_adder.sv
// Signed adder that clamps to the AW-bit two's-complement range and flags
// when clamping happened.
module sat_adder
  import booth_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          sat
);

  localparam logic [AW-1:0] MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MIN = {1'b1, {(AW-1){1'b0}}};

  logic [AW:0] wide;

  always_comb begin
    wide = {a[AW-1], a} + {b[AW-1], b};
    // The two top bits disagree only when the true sum left the AW-bit range.
    sat  = wide[AW] ^ wide[AW-1];
    if (!sat)
      sum = wide[AW-1:0];
    else if (wide[AW])
      sum = MIN;
    else
      sum = MAX;
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of signed products into a saturating accumulator and presents
// each group total on a valid/ready result port.
//
// state  | meaning
// S_IDLE | waiting for the first product of a group
// S_ACC  | group open, accumulating further products
// S_OUT  | group total presented, waiting for out_ready
module product_accumulator
  import booth_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  product_accumulator_if.slave   bus
);

  acc_state_t    state_q;
  acc_state_t    state_d;
  logic [AW-1:0] acc_q;
  logic          ovf_q;
  logic [LW-1:0] rem_q;
  logic [AW-1:0] prod_ext;
  logic [AW-1:0] add_sum;
  logic          add_sat;
  logic          beat;

  assign prod_ext = AW'($signed(bus.in_product));
  assign beat     = bus.in_valid & bus.in_ready;

  sat_adder #(.AW(AW)) u_sat_adder (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (beat) state_d = (bus.cfg_len == LW'(1)) ? S_OUT : S_ACC;
      S_ACC:  if (beat && rem_q == LW'(1)) state_d = S_OUT;
      S_OUT:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // rem_q counts the beats still owed after the current one; loading
  // cfg_len-1 makes a length of 0 wrap to 2^LW-1, i.e. a 2^LW-beat group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      rem_q <= '0;
    end else if (beat) begin
      if (state_q == S_IDLE) begin
        acc_q <= prod_ext;
        ovf_q <= 1'b0;
        rem_q <= bus.cfg_len - LW'(1);
      end else begin
        acc_q <= add_sum;
        ovf_q <= ovf_q | add_sat;
        rem_q <= rem_q - LW'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q != S_OUT);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios plus
// randomised handshakes against a saturating-sum reference model.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  product_accumulator_if #(.PW(64), .AW(72), .LW(8)) bus ();
  product_accumulator_if #(.PW(64), .AW(66), .LW(8)) bus_s ();

  product_accumulator #(.PW(64), .AW(72), .LW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow accumulator so that saturation is reachable with 64-bit products.
  product_accumulator #(.PW(64), .AW(66), .LW(8)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  // Reference: running sum of the group, clamped to aw bits after every add.
  function automatic logic signed [79:0] ref_sum(input logic [63:0] ps[$], input int aw,
                                                 output bit ovf);
    logic signed [79:0] acc, mx, mn;
    mx  = (80'sd1 <<< (aw - 1)) - 80'sd1;
    mn  = -(80'sd1 <<< (aw - 1));
    acc = '0;
    ovf = 1'b0;
    foreach (ps[i]) begin
      acc = acc + 80'($signed(ps[i]));
      if (acc > mx) begin acc = mx; ovf = 1'b1; end
      else if (acc < mn) begin acc = mn; ovf = 1'b1; end
    end
    return acc;
  endfunction

  task automatic push(input logic [63:0] p);
    int t = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pop(input logic [71:0] exp_sum, input logic exp_ovf, input string name);
    int t = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL %s_valid: got %0b required 1", name, bus.out_valid);
    end
    n_cmp++;
    if (bus.out_sum !== exp_sum) begin
      n_err++; $display("FAIL %s_sum: got %h required %h", name, bus.out_sum, exp_sum);
    end
    n_cmp++;
    if (bus.out_ovf !== exp_ovf) begin
      n_err++; $display("FAIL %s_ovf: got %0b required %0b", name, bus.out_ovf, exp_ovf);
    end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b required 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 72'd0) begin n_err++; $display("FAIL rst_out_sum: got %h required 0", bus.out_sum); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_out_ovf: got %0b required 0", bus.out_ovf); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus.cfg_len = 8'd3;
    push(64'd6);
    push(-64'sd2);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %0b required 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0b required 1", bus.busy); end
    push(64'd10);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %0b required 1", bus.out_valid); end
    pop(72'd14, 1'b0, "basic");
  endtask

  task automatic test_single();
    logic [63:0] p;
    p = -64'sh7FFF_FFFF_0000_0001;
    bus.cfg_len = 8'd1;
    push(p);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: got %0b required 1", bus.out_valid); end
    pop({{8{p[63]}}, p}, 1'b0, "single");
  endtask

  // 256 beats of 0x3FFF_FFFF_0000_0000 total 0x3F_FFFF_FF00_0000_0000, which
  // stays inside 72 bits; the clamp itself is exercised on the 66-bit instance.
  logic [71:0] hold_exp;

  task automatic test_len256();
    logic [63:0] ps[$];
    logic signed [79:0] r;
    bit o;
    bus.cfg_len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) bus.cfg_len = 8'd5;
      push(64'h3FFF_FFFF_0000_0000);
      ps.push_back(64'h3FFF_FFFF_0000_0000);
      if (i < 255) begin
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL len256_early_valid beat %0d: got %0b required 0", i + 1, bus.out_valid); end
      end
    end
    r = ref_sum(ps, 72, o);
    hold_exp = 72'(r);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL len256_valid: got %0b required 1", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== hold_exp) begin n_err++; $display("FAIL len256_sum: got %h required %h", bus.out_sum, hold_exp); end
    n_cmp++; if (bus.out_ovf !== o) begin n_err++; $display("FAIL len256_ovf: got %0b required %0b", bus.out_ovf, o); end
  endtask

  task automatic test_hold();
    bus.cfg_len    = 8'd1;
    bus.in_valid   = 1'b1;
    bus.in_product = 64'd5;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready cyc %0d: got %0b required 0", i, bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid cyc %0d: got %0b required 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_sum !== hold_exp) begin n_err++; $display("FAIL hold_sum cyc %0d: got %h required %h", i, bus.out_sum, hold_exp); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %0b required 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %0b required 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL release_busy_bypass: got %0b required 0", bus.busy); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    pop(72'd5, 1'b0, "after_hold");
  endtask

  task automatic test_reset_mid();
    bus.cfg_len = 8'd4;
    push(64'd7);
    push(64'd9);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %0b required 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %0b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_sum !== 72'd0) begin n_err++; $display("FAIL midrst_out_sum: got %h required 0", bus.out_sum); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL midrst_out_ovf: got %0b required 0", bus.out_ovf); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b required 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.cfg_len = 8'd2;
    push(64'd1);
    push(64'd1);
    pop(72'd2, 1'b0, "post_rst");
  endtask

  task automatic run_s(input logic [7:0] len, input logic [63:0] ps[$], input string name);
    logic signed [79:0] r;
    bit o;
    bus_s.cfg_len = len;
    foreach (ps[i]) begin
      bus_s.in_valid   = 1'b1;
      bus_s.in_product = ps[i];
      n_cmp++; if (bus_s.in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready beat %0d: got %0b required 1", name, i, bus_s.in_ready); end
      n_cmp++; if (bus_s.out_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_valid beat %0d: got %0b required 0", name, i, bus_s.out_valid); end
      @(posedge clk);
      @(negedge clk);
    end
    bus_s.in_valid = 1'b0;
    r = ref_sum(ps, 66, o);
    n_cmp++; if (bus_s.out_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %0b required 1", name, bus_s.out_valid); end
    n_cmp++; if (bus_s.out_sum !== 66'(r)) begin n_err++; $display("FAIL %s_sum: got %h required %h", name, bus_s.out_sum, 66'(r)); end
    n_cmp++; if (bus_s.out_ovf !== o) begin n_err++; $display("FAIL %s_ovf: got %0b required %0b", name, bus_s.out_ovf, o); end
    bus_s.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_s.out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    logic [63:0] ps[$];
    ps = {};
    repeat (6) ps.push_back(64'h7FFF_FFFF_FFFF_FFFF);
    repeat (2) ps.push_back(64'h8000_0000_0000_0000);
    run_s(8'd8, ps, "sat_pos_then_down");
    ps = {};
    repeat (5) ps.push_back(64'h8000_0000_0000_0000);
    run_s(8'd5, ps, "sat_neg");
    ps = {};
    repeat (256) ps.push_back(64'h3FFF_FFFF_0000_0000);
    run_s(8'd0, ps, "sat_len256");
    ps = {};
    ps.push_back(64'd3);
    ps.push_back(-64'sd1);
    run_s(8'd2, ps, "sat_clean");
  endtask

  task automatic test_random();
    localparam int NG = 12;
    logic [63:0] prods[$];
    logic [71:0] exp_sum[$];
    bit          exp_ovf[$];
    logic [63:0] grp[$];
    logic signed [79:0] r;
    bit o;
    bus.cfg_len = 8'd4;
    for (int i = 0; i < NG * 4; i++) prods.push_back({$urandom, $urandom});
    for (int g = 0; g < NG; g++) begin
      grp = prods[g*4 : g*4+3];
      r = ref_sum(grp, 72, o);
      exp_sum.push_back(72'(r));
      exp_ovf.push_back(o);
    end
    fork
      begin
        for (int i = 0; i < NG * 4; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          push(prods[i]);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < NG && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (bus.out_sum !== exp_sum[got]) begin n_err++; $display("FAIL rand_sum grp %0d: got %h required %h", got, bus.out_sum, exp_sum[got]); end
            n_cmp++;
            if (bus.out_ovf !== exp_ovf[got]) begin n_err++; $display("FAIL rand_ovf grp %0d: got %0b required %0b", got, bus.out_ovf, exp_ovf[got]); end
            got++;
          end
        end
        if (got < NG) begin
          n_cmp++; n_err++;
          $display("FAIL rand_timeout: got %0d groups required %0d", got, NG);
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rand_leftover_busy: got %0b required 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rand_extra_result: got %0b required 0", bus.out_valid); end
  endtask

  initial begin
    bus.cfg_len      = 8'd0;
    bus.in_valid     = 1'b0;
    bus.in_product   = 64'd0;
    bus.out_ready    = 1'b0;
    bus_s.cfg_len    = 8'd0;
    bus_s.in_valid   = 1'b0;
    bus_s.in_product = 64'd0;
    bus_s.out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_len256();
    test_hold();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
